// File: rtl/pzcorebus_memory_l_responder.sv
// Word-addressed memory responder for the corebus: bursts write into and read out of a local register array.
// Latency: first read beat the cycle after command accept; write response the cycle after the last data beat.
// Backpressure: one command at a time; response fields hold until sresp_accept.
module pzcorebus_memory_l_responder #(
    parameter int ID_WIDTH      = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_LENGTH    = 8,
    parameter int DEPTH         = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    output logic                            scmd_accept,
    input  logic                            mcmd_valid,
    input  logic [3:0]                      mcmd,
    input  logic [ID_WIDTH-1:0]             mid,
    input  logic [ADDRESS_WIDTH-1:0]        maddr,
    input  logic [((MAX_LENGTH == 1) ? 1 : $clog2(MAX_LENGTH))-1:0] mlength,
    output logic                            mdata_accept,
    input  logic                            mdata_valid,
    input  logic [DATA_WIDTH-1:0]           mdata,
    input  logic [DATA_WIDTH/8-1:0]         mdata_byteen,
    input  logic                            mdata_last,
    output logic                            sresp_valid,
    input  logic                            sresp_accept,
    output logic                            sresp,
    output logic [ID_WIDTH-1:0]             sid,
    output logic                            serror,
    output logic [DATA_WIDTH-1:0]           sdata,
    output logic                            sresp_last
);
    localparam int OFFSET = $clog2(DATA_WIDTH / 8);
    localparam int IDXW   = $clog2(DEPTH);
    localparam int CNTW   = $clog2(MAX_LENGTH) + 1;
    localparam int BEW    = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state_q;
    logic [ID_WIDTH-1:0]   mid_q;
    logic [IDXW-1:0]       idx_q;
    logic [CNTW-1:0]       cnt_q;
    logic                  err_q;
    logic                  np_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic            cmd_fire;
    logic            data_fire;
    logic            resp_fire;
    logic            addr_err;
    logic            cmd_storable;
    logic            cnt_is_one;
    logic [CNTW-1:0] cnt_init;

    assign cmd_fire     = mcmd_valid & scmd_accept;
    assign data_fire    = mdata_valid & mdata_accept;
    assign resp_fire    = sresp_valid & sresp_accept;
    assign addr_err     = |(maddr >> (OFFSET + IDXW));
    // Only plain/full writes (posted or not) carry storable data; bit 1 marks broadcast/atomic.
    assign cmd_storable = mcmd[2] & ~mcmd[1];
    assign cnt_is_one   = (cnt_q == CNTW'(1));
    assign cnt_init     = (mlength == '0) ? CNTW'(MAX_LENGTH) : CNTW'(mlength);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mid_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            np_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        mid_q <= mid;
                        idx_q <= maddr[OFFSET+:IDXW];
                        cnt_q <= cnt_init;
                        np_q  <= mcmd[3];
                        if (mcmd[2]) begin
                            state_q <= WRITE;
                            err_q   <= addr_err | ~cmd_storable;
                        end else if (mcmd == 4'b1001) begin
                            state_q <= READ;
                            err_q   <= addr_err;
                        end else if (mcmd[3]) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (data_fire) begin
                        idx_q <= idx_q + IDXW'(1);
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                        // Burst length mismatch in either direction poisons the rest of the burst.
                        if (mdata_last != cnt_is_one) begin
                            err_q <= 1'b1;
                        end
                        if (mdata_last) begin
                            state_q <= np_q ? RESP : IDLE;
                        end
                    end
                end
                READ: begin
                    if (resp_fire) begin
                        if (cnt_is_one) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                end
                default: begin
                    if (resp_fire) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state_q == WRITE) && data_fire && !err_q) begin
            for (int b = 0; b < BEW; b++) begin
                if (mdata_byteen[b]) begin
                    mem[idx_q][8*b+:8] <= mdata[8*b+:8];
                end
            end
        end
    end

    always_comb begin
        scmd_accept  = (state_q == IDLE);
        mdata_accept = (state_q == WRITE);
        sresp_valid  = (state_q == READ) || (state_q == RESP);
        sresp        = (state_q == READ);
        sid          = mid_q;
        serror       = sresp_valid & err_q;
        sdata        = ((state_q == READ) && !err_q) ? mem[idx_q] : '0;
        sresp_last   = (state_q == RESP) || ((state_q == READ) && cnt_is_one);
    end

endmodule

// File: tb/tb_pzcorebus_memory_l_responder.sv
// Directed bench for the memory responder; a monitor pops expected response beats from a queue.
module tb_pzcorebus_memory_l_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scmd_accept;
    logic        mcmd_valid = 1'b0;
    logic [3:0]  mcmd = 4'h0;
    logic [7:0]  mid = 8'h0;
    logic [31:0] maddr = 32'h0;
    logic [2:0]  mlength = 3'h0;
    logic        mdata_accept;
    logic        mdata_valid = 1'b0;
    logic [31:0] mdata = 32'h0;
    logic [3:0]  mdata_byteen = 4'h0;
    logic        mdata_last = 1'b0;
    logic        sresp_valid;
    logic        sresp_accept = 1'b1;
    logic        sresp;
    logic [7:0]  sid;
    logic        serror;
    logic [31:0] sdata;
    logic        sresp_last;

    int total = 0;
    int bad = 0;
    int pops = 0;
    bit acc_mode = 1'b0;
    logic [42:0] exp_q [$];
    logic [31:0] ref_mem [64];
    logic [31:0] beat_dat [8];
    logic [3:0]  beat_be [8];

    pzcorebus_memory_l_responder dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .scmd_accept(scmd_accept), .mcmd_valid(mcmd_valid), .mcmd(mcmd), .mid(mid),
        .maddr(maddr), .mlength(mlength),
        .mdata_accept(mdata_accept), .mdata_valid(mdata_valid), .mdata(mdata),
        .mdata_byteen(mdata_byteen), .mdata_last(mdata_last),
        .sresp_valid(sresp_valid), .sresp_accept(sresp_accept), .sresp(sresp), .sid(sid),
        .serror(serror), .sdata(sdata), .sresp_last(sresp_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (acc_mode) sresp_accept = ~sresp_accept;
        else          sresp_accept = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: compares each accepted beat and checks fields hold while stalled.
    logic [42:0] held;
    bit stalled = 1'b0;
    always @(negedge clk) begin
        logic [42:0] cur;
        logic [42:0] e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            cur = {sresp, sid, serror, sdata, sresp_last};
            if (stalled) begin
                chk("resp_valid_hold", {63'h0, sresp_valid}, 64'h1);
                if (sresp_valid) chk("resp_fields_hold", {21'h0, cur}, {21'h0, held});
            end
            stalled = 1'b0;
            if (sresp_valid) begin
                if (sresp_accept) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got %h want none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_beat", {21'h0, cur}, {21'h0, e});
                    end
                    pops++;
                end else begin
                    held = cur;
                    stalled = 1'b1;
                end
            end
        end
    end

    task automatic send_cmd(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                            input logic [7:0] id);
        bit ok = 1'b0;
        mcmd_valid = 1'b1; mcmd = c; maddr = a; mlength = l; mid = id;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (scmd_accept) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL cmd_timeout: got no scmd_accept want accept");
        end
        @(posedge clk); #1;
        mcmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] be, input logic last);
        bit ok = 1'b0;
        mdata_valid = 1'b1; mdata = d; mdata_byteen = be; mdata_last = last;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (mdata_accept) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL data_timeout: got no mdata_accept want accept");
        end
        @(posedge clk); #1;
        mdata_valid = 1'b0;
    endtask

    // store[i] marks which beats the bench expects to land in memory.
    task automatic wr(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                      input logic [7:0] id, input int nb, input logic [7:0] store,
                      input logic exp_err);
        int base = int'(a[7:2]);
        if (c[3]) exp_q.push_back({1'b0, id, exp_err, 32'h0, 1'b1});
        send_cmd(c, a, l, id);
        for (int i = 0; i < nb; i++) begin
            send_beat(beat_dat[i], beat_be[i], i == nb - 1);
            if (store[i]) begin
                for (int b = 0; b < 4; b++)
                    if (beat_be[i][b]) ref_mem[(base + i) % 64][8*b+:8] = beat_dat[i][8*b+:8];
            end
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] l, input logic [7:0] id,
                      input int nb, input logic exp_err);
        int base = int'(a[7:2]);
        for (int i = 0; i < nb; i++)
            exp_q.push_back({1'b1, id, exp_err, exp_err ? 32'h0 : ref_mem[(base + i) % 64],
                             i == nb - 1});
        send_cmd(4'b1001, a, l, id);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scmd_accept", {63'h0, scmd_accept}, 64'h1);
        chk("rst_mdata_accept", {63'h0, mdata_accept}, 64'h0);
        chk("rst_sresp_valid", {63'h0, sresp_valid}, 64'h0);
        chk("rst_sresp", {63'h0, sresp}, 64'h0);
        chk("rst_sid", {56'h0, sid}, 64'h0);
        chk("rst_serror", {63'h0, serror}, 64'h0);
        chk("rst_sdata", {32'h0, sdata}, 64'h0);
        chk("rst_sresp_last", {63'h0, sresp_last}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-posted write then read back.
        beat_dat[0] = 32'hA5A5A5A5; beat_be[0] = 4'hF;
        beat_dat[1] = 32'h5A5A5A5A; beat_be[1] = 4'hF;
        wr(4'b1100, 32'h10, 3'd2, 8'h11, 2, 8'h03, 1'b0);
        wait_drain();
        rd(32'h10, 3'd2, 8'h12, 2, 1'b0);
        wait_drain();

        // Broadcast data is drained, not stored; posted so no response.
        beat_dat[0] = 32'hFFFFFFFF; beat_be[0] = 4'hF;
        wr(4'b0110, 32'h10, 3'd1, 8'h13, 1, 8'h00, 1'b1);
        rd(32'h10, 3'd1, 8'h14, 1, 1'b0);
        wait_drain();

        // Posted write wrapping from word 63 to word 0.
        beat_dat[0] = 32'h11111111; beat_be[0] = 4'hF;
        beat_dat[1] = 32'h22222222; beat_be[1] = 4'hF;
        wr(4'b0100, 32'hFC, 3'd2, 8'h21, 2, 8'h03, 1'b0);
        rd(32'hFC, 3'd2, 8'h22, 2, 1'b0);
        rd(32'h00, 3'd1, 8'h23, 1, 1'b0);
        wait_drain();
        chk("wrap_word0", {32'h0, ref_mem[0]}, 64'h22222222);

        // Out-of-range read.
        rd(32'h100, 3'd1, 8'h31, 1, 1'b1);
        wait_drain();

        // Non-posted message errors; posted message and NULL produce nothing.
        exp_q.push_back({1'b0, 8'h41, 1'b1, 32'h0, 1'b1});
        send_cmd(4'b1011, 32'h0, 3'd1, 8'h41);
        send_cmd(4'b0001, 32'h0, 3'd1, 8'h42);
        send_cmd(4'b0000, 32'h0, 3'd1, 8'h43);
        wait_drain();

        // Short burst: last on beat 1 of 3; that beat's enabled bytes still land.
        beat_dat[0] = 32'hDEADBEEF; beat_be[0] = 4'b0011;
        wr(4'b1100, 32'h20, 3'd3, 8'h51, 1, 8'h01, 1'b1);
        wait_drain();
        chk("short_burst_word8", {32'h0, ref_mem[8]}, 64'h0000BEEF);
        // Long burst: second beat is beyond the length and is dropped.
        beat_dat[0] = 32'hCAFEF00D; beat_be[0] = 4'hF;
        beat_dat[1] = 32'h12345678; beat_be[1] = 4'hF;
        wr(4'b1100, 32'h30, 3'd1, 8'h52, 2, 8'h01, 1'b1);
        rd(32'h20, 3'd2, 8'h53, 2, 1'b0);
        rd(32'h30, 3'd2, 8'h54, 2, 1'b0);
        wait_drain();

        // Max-length read (mlength 0) under toggling backpressure.
        acc_mode = 1'b1;
        rd(32'h10, 3'd0, 8'h61, 8, 1'b0);
        wait_drain();
        acc_mode = 1'b0;
        @(posedge clk); #1;

        // Reset during beat 3 of an 8-beat read.
        base = pops;
        rd(32'h10, 3'd0, 8'h71, 8, 1'b0);
        for (int i = 0; i < 500 && pops < base + 2; i++) @(negedge clk);
        chk("pre_reset_beats", 64'(pops - base), 64'd2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_sresp_valid", {63'h0, sresp_valid}, 64'h0);
        chk("midreset_scmd_accept", {63'h0, scmd_accept}, 64'h1);
        exp_q.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_scmd_accept", {63'h0, scmd_accept}, 64'h1);
        chk("post_reset_sresp_valid", {63'h0, sresp_valid}, 64'h0);
        @(posedge clk); #1;
        rd(32'h10, 3'd1, 8'h72, 1, 1'b0);
        rd(32'hFC, 3'd1, 8'h73, 1, 1'b0);
        wait_drain();

        repeat (5) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pzcorebus_memory_l_responder.md
PZCOREBUS_MEMORY_L_RESPONDER -- requirements
Module: pzcorebus_memory_l_responder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ID_WIDTH, 8, mid/sid width; ADDRESS_WIDTH, 32, byte address width; DATA_WIDTH, 32, data width (multiple of 32); MAX_LENGTH, 8, max burst words; DEPTH, 64, word count of internal storage (power of 2).
REQ-002 Ports SHALL be (name direction width meaning): i_clk in 1 clock; i_rst_n in 1 reset, asynchronous, active-low.
REQ-003 Command: scmd_accept out 1; mcmd_valid in 1; mcmd in 4 (command type encoding); mid in ID_WIDTH; maddr in ADDRESS_WIDTH; mlength in clog2(MAX_LENGTH), or 1 if MAX_LENGTH==1.
REQ-004 Write data: mdata_accept out 1; mdata_valid in 1; mdata in DATA_WIDTH; mdata_byteen in DATA_WIDTH/8; mdata_last in 1.
REQ-005 Response: sresp_valid out 1; sresp_accept in 1; sresp out 1 (0 RESPONSE, 1 RESPONSE_WITH_DATA); sid out ID_WIDTH; serror out 1; sdata out DATA_WIDTH; sresp_last out 1.
REQ-006 Clocking: single clock i_clk; reset i_rst_n asynchronous assert, active-low; all flops on posedge i_clk.

Function
REQ-007 FSM SHALL have states IDLE, WRITE, READ, RESP; scmd_accept=1 only in IDLE; mdata_accept=1 only in WRITE; sresp_valid=1 only in READ or RESP.
REQ-008 Handshake: transfer occurs on a cycle when valid and accept are both 1; sresp_valid and all response fields SHALL hold stable until sresp_accept.
REQ-009 On command accept: latch mid, word index = maddr[log2(DATA_WIDTH/8) +: log2(DEPTH)], beat count = mlength, with mlength==0 meaning MAX_LENGTH.
REQ-010 Range error: any maddr bit at or above log2(DATA_WIDTH/8)+log2(DEPTH) set SHALL set a latched error flag; no storage access for that command.
REQ-011 mcmd bit 2 (with-data) set -> WRITE; READ (4'b1001) -> READ; any other non-posted command without data -> RESP, serror=1; posted command without data (incl. NULL) -> stay IDLE, no response.
REQ-012 WRITE: per accepted beat, bytes with mdata_byteen=1 written to storage at word index, unless error flag set; word index increments modulo DEPTH (wrap to 0); beat count decrements.
REQ-013 WRITE exits on the accepted beat with mdata_last=1; if that beat's count differs from 1, or count reaches 1 without mdata_last, error flag set; beats continue to be drained until mdata_last.
REQ-014 Only WRITE, FULL_WRITE, WRITE_NON_POSTED, FULL_WRITE_NON_POSTED store data; BROADCAST/ATOMIC/MESSAGE data is drained, not stored, and sets error flag.
REQ-015 After WRITE: non-posted (mcmd bit 3) -> RESP; posted -> IDLE with no response; posted errors silently dropped.
REQ-016 RESP: one beat, sresp=0, sid=latched mid, serror=error flag, sdata=0, sresp_last=1; on sresp_accept -> IDLE.
REQ-017 READ: sresp=1, sid=latched mid, sdata=storage[word index] (0 when error), serror=error flag, sresp_last=1 on final beat; per accepted beat, index increments modulo DEPTH, count decrements; final accepted beat -> IDLE.
REQ-018 Read latency: first sresp_valid the cycle after command accept; back-to-back beats with no bubble while sresp_accept=1.
REQ-019 Write-then-read to same address SHALL return the newly written data (write completes before next command accepted).
REQ-020 Error flag clears on each command accept.

Reset
REQ-021 While i_rst_n=0: state IDLE, scmd_accept=1, mdata_accept=0, sresp_valid=0, sresp=0, sid=0, serror=0, sdata=0, sresp_last=0, counters/flags 0, storage all 0.
REQ-022 Reset asserted mid-burst SHALL abandon the transaction immediately; no response beat issued after reset release.

Verification
REQ-023 WRITE_NON_POSTED addr 0x10, mlength 2, data 0xA5A5A5A5/0x5A5A5A5A byteen F/F -> one response sresp=0 serror=0 sresp_last=1; READ addr 0x10 mlength 2 -> sdata 0xA5A5A5A5 then 0x5A5A5A5A, last on beat 2.
REQ-024 Posted WRITE addr 0xFC (DEPTH 64, 32b), mlength 2 -> words 63 and 0 written (wrap); no response; READ confirms.
REQ-025 READ addr 0x100 (out of range) mlength 1 -> one beat serror=1 sdata=0 sresp_last=1.
REQ-026 MESSAGE_NON_POSTED -> single response serror=1; mdata_last on beat 1 of mlength 3 write -> serror=1, storage unchanged beyond written bytes per REQ-012.
REQ-027 READ mlength 0 (MAX_LENGTH 8) with sresp_accept toggling -> exactly 8 beats, fields stable while stalled.
REQ-028 Reset asserted during beat 3 of 8-beat read -> sresp_valid=0 immediately, scmd_accept=1 after release.
